// File: rtl/knn_vote_unit.sv
// knn_vote_unit
//   Consumes one sorted vector of N = 1<<L distance/label pairs from the
//   bitonic sorter. Walks the K nearest entries one per cycle, counting
//   votes per class. Then presents the winning label, its vote count and
//   the nearest distance on a valid/ready handshake.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   in_valid_i/in_ready_o   vector handshake (ready only in IDLE)
//   ascending_i             sort direction of in_i, sampled with the vector
//   in_i [W*N]              sorted distances, entry i at [W*(i+1)-1:W*i]
//   in_type_i [TYPE_W*N]    class labels, same layout
//   out_class_o/out_votes_o/out_min_dist_o  registered result
//   out_valid_o/out_ready_i result handshake
//
// Build option
//   KNN_NEAREST_TIE_EN : a tie goes to the tied class whose first vote came
//   from the nearest entry. This adds per-class first-vote index registers.
//   Without it, a tie goes to the lowest class index.
module knn_vote_unit #(
  parameter int L      = 3,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 5,
  parameter int CW     = $clog2(K+1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     ascending_i,
  input  logic [W*(1<<L)-1:0]      in_i,
  input  logic [TYPE_W*(1<<L)-1:0] in_type_i,
  output logic [TYPE_W-1:0]        out_class_o,
  output logic [CW-1:0]            out_votes_o,
  output logic [W-1:0]             out_min_dist_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);
  localparam int N  = 1 << L;
  localparam int NC = 1 << TYPE_W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DECIDE, HOLD} state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               i_q, i_d;
  logic [NC-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0][TYPE_W-1:0]    type_q, type_d;
  logic                        asc_q, asc_d;
  logic [W-1:0]                near_q, near_d;
  logic [TYPE_W-1:0]           cls_q, cls_d;
  logic [CW-1:0]               votes_q, votes_d;
  logic [W-1:0]                mind_q, mind_d;
`ifdef KNN_NEAREST_TIE_EN
  logic [NC-1:0][IW-1:0]       first_q, first_d;
  logic [IW-1:0]               best_f;
`endif

  logic [N-1:0][W-1:0]      in_arr;
  logic [N-1:0][TYPE_W-1:0] in_type_arr;
  logic [L-1:0]             e_idx;
  logic [TYPE_W-1:0]        sel_t;
  logic [TYPE_W-1:0]        best_c;
  logic [CW-1:0]            best_v;
  logic                     unused_in;

  assign in_arr      = in_i;
  assign in_type_arr = in_type_i;
  // Only the two end entries of the distance vector are ever read.
  assign unused_in   = ^in_i;

  // Walk from the near end of the vector in both directions.
  assign e_idx = asc_q ? L'(i_q) : L'(N-1) - L'(i_q);
  assign sel_t = type_q[e_idx];

  // Argmax over the class counters. A strict '>' keeps the lowest index on
  // a tie. With the nearest-tie option, an equal count replaces the current
  // best when that class voted earlier.
  always_comb begin
    best_c = '0;
    best_v = '0;
`ifdef KNN_NEAREST_TIE_EN
    best_f = '1;
`endif
    for (int c = 0; c < NC; c++) begin
`ifdef KNN_NEAREST_TIE_EN
      if (cnt_q[c] > best_v ||
          (cnt_q[c] == best_v && cnt_q[c] != '0 && first_q[c] < best_f)) begin
        best_f = first_q[c];
`else
      if (cnt_q[c] > best_v) begin
`endif
        best_c = TYPE_W'(c);
        best_v = cnt_q[c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    asc_d   = asc_q;
    near_d  = near_q;
    cls_d   = cls_q;
    votes_d = votes_q;
    mind_d  = mind_q;
`ifdef KNN_NEAREST_TIE_EN
    first_d = first_q;
`endif
    case (state_q)
      IDLE: if (in_valid_i) begin
        type_d  = in_type_arr;
        asc_d   = ascending_i;
        near_d  = ascending_i ? in_arr[0] : in_arr[N-1];
        cnt_d   = '0;
        i_d     = '0;
        state_d = COUNT;
      end
      COUNT: begin
        cnt_d[sel_t] = cnt_q[sel_t] + CW'(1);
`ifdef KNN_NEAREST_TIE_EN
        if (cnt_q[sel_t] == '0) first_d[sel_t] = i_q;
`endif
        if (i_q == IW'(K-1)) state_d = DECIDE;
        else                 i_d     = i_q + IW'(1);
      end
      DECIDE: begin
        cls_d   = best_c;
        votes_d = best_v;
        mind_d  = near_q;
        state_d = HOLD;
      end
      HOLD: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      i_q     <= '0;
      cnt_q   <= '0;
      type_q  <= '0;
      asc_q   <= 1'b0;
      near_q  <= '0;
      cls_q   <= '0;
      votes_q <= '0;
      mind_q  <= '0;
`ifdef KNN_NEAREST_TIE_EN
      first_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      asc_q   <= asc_d;
      near_q  <= near_d;
      cls_q   <= cls_d;
      votes_q <= votes_d;
      mind_q  <= mind_d;
`ifdef KNN_NEAREST_TIE_EN
      first_q <= first_d;
`endif
    end
  end

  assign in_ready_o     = (state_q == IDLE);
  assign out_valid_o    = (state_q == HOLD);
  assign out_class_o    = cls_q;
  assign out_votes_o    = votes_q;
  assign out_min_dist_o = mind_q;
endmodule

// File: tb/tb_knn_vote_unit.sv
module tb_knn_vote_unit;
  localparam int K = 5;
  typedef logic [7:0][15:0] vec_t;
  typedef logic [7:0][2:0]  typ_t;
  typedef struct { logic [2:0] cls; logic [2:0] votes; logic [15:0] mind; } res_t;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_valid4 = 0, asc = 1, out_ready = 1, out_ready4 = 1;
  vec_t din = '0;
  typ_t tin = '0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [2:0] out_class, out_votes, out_class4, out_votes4;
  logic [15:0] out_min_dist, out_min_dist4;

  int total = 0, bad = 0;
  res_t q[$];
  res_t mexp;

  always #5 clk = ~clk;

  knn_vote_unit #(.L(3), .W(16), .TYPE_W(3), .K(K)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ascending_i(asc), .in_i(din), .in_type_i(tin), .out_class_o(out_class),
    .out_votes_o(out_votes), .out_min_dist_o(out_min_dist),
    .out_valid_o(out_valid), .out_ready_i(out_ready));

  knn_vote_unit #(.L(3), .W(16), .TYPE_W(3), .K(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .ascending_i(asc), .in_i(din), .in_type_i(tin), .out_class_o(out_class4),
    .out_votes_o(out_votes4), .out_min_dist_o(out_min_dist4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4));

  // Reference: count the k nearest labels, then break ties either by the
  // nearest voting entry or by the lowest class number.
  function automatic res_t model(vec_t d, typ_t t, bit a, int k);
    int cnt[8];
    int mx = 0;
    int e;
    res_t r;
    r.cls = 0;
    foreach (cnt[c]) cnt[c] = 0;
    for (int j = 0; j < k; j++) begin
      e = a ? j : 7 - j;
      cnt[t[e]]++;
    end
    foreach (cnt[c]) if (cnt[c] > mx) mx = cnt[c];
`ifdef KNN_NEAREST_TIE_EN
    for (int j = k - 1; j >= 0; j--) begin
      e = a ? j : 7 - j;
      if (cnt[t[e]] == mx) r.cls = t[e];
    end
`else
    for (int c = 7; c >= 0; c--) if (cnt[c] == mx) r.cls = 3'(c);
`endif
    r.votes = 3'(mx);
    r.mind  = a ? d[0] : d[7];
    return r;
  endfunction

  function automatic typ_t mk_types(input int a[8]);
    typ_t t;
    for (int i = 0; i < 8; i++) t[i] = 3'(a[i]);
    return t;
  endfunction

  function automatic vec_t mk_dist(input bit a);
    vec_t d;
    for (int i = 0; i < 8; i++) d[i] = a ? 16'(100 + 10*i) : 16'(1000 - 10*i);
    return d;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 8; i++) begin
      din[i] = 16'($urandom);
      tin[i] = 3'($urandom);
    end
  endtask

  // Scoreboard monitor: every completed result handshake pops one entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: result cls=%0d with no expected entry", out_class);
      end else begin
        mexp = q.pop_front();
        total += 3;
        if (out_class !== mexp.cls) begin bad++; $display("FAIL sb_class: got %0d want %0d", out_class, mexp.cls); end
        if (out_votes !== mexp.votes) begin bad++; $display("FAIL sb_votes: got %0d want %0d", out_votes, mexp.votes); end
        if (out_min_dist !== mexp.mind) begin bad++; $display("FAIL sb_mind: got %0d want %0d", out_min_dist, mexp.mind); end
      end
    end
  end

  // Offer one vector to the main unit. Return the cycles from accept until
  // out_valid is seen. Inputs are scrambled right after the accept edge.
  task automatic send(input vec_t d, input typ_t t, input bit a, output int lat);
    int w = 0;
    din = d; tin = t; asc = a; in_valid = 1;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    total++;
    if (!in_ready) begin bad++; $display("FAIL accept_wait: in_ready=%0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    q.push_back(model(d, t, a, K));
    scramble();
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL %s_drain: pending=%0d want 0", nm, q.size()); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_class !== 3'd0) begin bad++; $display("FAIL rst_class: got %0d want 0", out_class); end
    if (out_votes !== 3'd0) begin bad++; $display("FAIL rst_votes: got %0d want 0", out_votes); end
    if (out_min_dist !== 16'd0) begin bad++; $display("FAIL rst_mind: got %0d want 0", out_min_dist); end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_vote(input bit a, input int want_cls, input string nm);
    int lat;
    int ta[8] = '{2, 2, 1, 3, 2, 0, 0, 0};
    out_ready = 1;
    send(mk_dist(a), mk_types(ta), a, lat);
    total += 2;
    if (lat != K + 1) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, K + 1); end
    if (out_class !== 3'(want_cls)) begin bad++; $display("FAIL %s_class_const: got %0d want %0d", nm, out_class, want_cls); end
    drain(nm);
  endtask

  task automatic test_tie();
    int lat, n;
    res_t r;
    int ta[8] = '{3, 1, 1, 3, 0, 4, 4, 4};
    int tb[8] = '{3, 1, 1, 3, 0, 0, 0, 0};
    int tc[8] = '{0, 0, 0, 0, 5, 2, 2, 5};
    // K=5 tie on the main unit, checked through the scoreboard.
    send(mk_dist(1), mk_types(ta), 1, lat);
    drain("tie5");
    // K=4 ties on the second unit: ascending, then descending.
    for (int c = 0; c < 2; c++) begin
      asc = (c == 0);
      din = mk_dist(asc);
      tin = (c == 0) ? mk_types(tb) : mk_types(tc);
      r = model(din, tin, asc, 4);
      in_valid4 = 1;
      @(posedge clk); #1;
      in_valid4 = 0;
      n = 0;
      while (!out_valid4 && n < 50) begin @(posedge clk); #1; n++; end
      total += 4;
      if (n != 5) begin bad++; $display("FAIL tie4_latency[%0d]: got %0d want 5", c, n); end
      if (out_class4 !== r.cls) begin bad++; $display("FAIL tie4_class[%0d]: got %0d want %0d", c, out_class4, r.cls); end
      if (out_votes4 !== 3'd2) begin bad++; $display("FAIL tie4_votes[%0d]: got %0d want 2", c, out_votes4); end
      if (out_min_dist4 !== r.mind) begin bad++; $display("FAIL tie4_mind[%0d]: got %0d want %0d", c, out_min_dist4, r.mind); end
      if (c == 0) begin
        total++;
`ifdef KNN_NEAREST_TIE_EN
        if (out_class4 !== 3'd3) begin bad++; $display("FAIL tie4_const: got %0d want 3", out_class4); end
`else
        if (out_class4 !== 3'd1) begin bad++; $display("FAIL tie4_const: got %0d want 1", out_class4); end
`endif
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int ta[8] = '{6, 4, 6, 1, 6, 2, 2, 2};
    res_t r;
    out_ready = 0;
    send(mk_dist(1), mk_types(ta), 1, lat);
    r = q[0];
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      scramble();
      @(negedge clk);
      total += 5;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      if (out_class !== r.cls) begin bad++; $display("FAIL bp_class[%0d]: got %0d want %0d", c, out_class, r.cls); end
      if (out_votes !== r.votes) begin bad++; $display("FAIL bp_votes[%0d]: got %0d want %0d", c, out_votes, r.votes); end
      if (out_min_dist !== r.mind) begin bad++; $display("FAIL bp_mind[%0d]: got %0d want %0d", c, out_min_dist, r.mind); end
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid: got %b want 0", out_valid); end
    if (q.size() != 0) begin bad++; $display("FAIL bp_pending: got %0d want 0", q.size()); end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_consume: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int ta[8] = '{7, 7, 7, 7, 7, 7, 7, 7};
    int tf[8] = '{4, 5, 4, 1, 1, 3, 3, 3};
    din = mk_dist(1); tin = mk_types(ta); asc = 1; in_valid = 1;
    @(posedge clk); #1;          // accept, first COUNT cycle follows
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;          // third COUNT cycle
    rst_n = 0;
    #1;
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    if (out_class !== 3'd0) begin bad++; $display("FAIL abort_class: got %0d want 0", out_class); end
    if (out_votes !== 3'd0) begin bad++; $display("FAIL abort_votes: got %0d want 0", out_votes); end
    if (out_min_dist !== 16'd0) begin bad++; $display("FAIL abort_mind: got %0d want 0", out_min_dist); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    send(mk_dist(1), mk_types(tf), 1, lat);
    total++;
    if (lat != K + 1) begin bad++; $display("FAIL abort_latency: got %0d want %0d", lat, K + 1); end
    drain("abort");
  endtask

  task automatic test_back_to_back();
    vec_t va, vb;
    typ_t ta, tb;
    int a1 = -1, a2 = -1, cyc = 0;
    bit acc;
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'(50 + 3*i);   ta[i] = 3'($urandom);
      vb[i] = 16'(900 - 7*i);  tb[i] = 3'($urandom);
    end
    out_ready = 1;
    din = va; tin = ta; asc = 1; in_valid = 1;
    while (a2 < 0 && cyc < 40) begin
      acc = in_valid && in_ready;
      @(posedge clk); cyc++;
      if (acc && a1 < 0) begin
        a1 = cyc; q.push_back(model(va, ta, 1, K));
        #1; din = vb; tin = tb; asc = 0;
      end else if (acc) begin
        a2 = cyc; q.push_back(model(vb, tb, 0, K));
        #1; in_valid = 0;
      end else #1;
    end
    in_valid = 0;
    total++;
    if (a2 - a1 != K + 3) begin bad++; $display("FAIL b2b_period: got %0d want %0d", a2 - a1, K + 3); end
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_vote(1, 2, "vote_asc");
    test_vote(0, 0, "vote_desc");
    test_tie();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
